// File: rtl/data_mem_ctrl_if.sv
// Core-to-data-memory access bus: request fields driven by the core (master),
// ready/load-data/error returned by the controller (slave).
interface data_mem_ctrl_if;
    logic [31:0] i_data_addr;
    logic [31:0] i_data_wr;
    logic [1:0]  i_data_rd_en_ctrl;
    logic        i_data_rd_en_ma;
    logic        i_data_wr_en_ma;
    logic        o_data_ready;
    logic [31:0] o_data_rd;
    logic        o_data_err;

    modport master (
        output i_data_addr, i_data_wr, i_data_rd_en_ctrl, i_data_rd_en_ma, i_data_wr_en_ma,
        input  o_data_ready, o_data_rd, o_data_err
    );

    modport slave (
        input  i_data_addr, i_data_wr, i_data_rd_en_ctrl, i_data_rd_en_ma, i_data_wr_en_ma,
        output o_data_ready, o_data_rd, o_data_err
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: word SRAM model with size-qualified loads/stores and WAIT_STATES stalls.
// Optional DMEM_ACCESS_COUNT_EN adds successful load/store counters.
module data_mem_ctrl #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    data_mem_ctrl_if.slave       dmem
`ifdef DMEM_ACCESS_COUNT_EN
    ,
    output logic [31:0]          o_rd_count,
    output logic [31:0]          o_wr_count
`endif
);
    localparam int unsigned IDX_W = $clog2(MEM_DEPTH);
    localparam int unsigned AW    = IDX_W + 2;
    localparam logic [3:0]  CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

    state_t                r_state;
    state_t                w_state_d;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_d;
    logic [AW-1:0]         r_addr;
    logic [1:0]            r_size;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_rd;
    logic                  r_wr;
    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

    logic                  w_req;
    logic                  w_latch;
    logic                  w_err;
    logic                  w_ready;
    logic [DATA_WIDTH-1:0] w_rd_out;
    logic                  w_err_out;
    logic [DATA_WIDTH-1:0] w_word;
    logic [DATA_WIDTH-1:0] w_word_sh;
    logic [DATA_WIDTH-1:0] w_load;
    logic [DATA_WIDTH-1:0] w_wdata_sh;
    logic [DATA_WIDTH-1:0] w_merged;
    logic [3:0]            w_be;
    logic [4:0]            w_shift;
    logic                  w_commit;

    assign w_req   = dmem.i_data_rd_en_ma | dmem.i_data_wr_en_ma;
    assign w_shift = {r_addr[1:0], 3'b000};
    assign w_word  = r_mem[r_addr[AW-1:2]];
    assign w_err   = (r_size == 2'b11) || (r_rd && r_wr) ||
                     (r_size == 2'b01 && r_addr[0]) ||
                     (r_size == 2'b10 && r_addr[1:0] != 2'b00);

    // Load lane extraction and store lane merge, both relative to the latched byte offset.
    always_comb begin
        w_word_sh  = w_word >> w_shift;
        w_wdata_sh = r_wdata << w_shift;
        w_load     = w_word;
        w_be       = 4'b1111;
        case (r_size)
            2'b00: begin
                w_load = {24'b0, w_word_sh[7:0]};
                w_be   = 4'b0001 << r_addr[1:0];
            end
            2'b01: begin
                w_load = {16'b0, w_word_sh[15:0]};
                w_be   = 4'b0011 << r_addr[1:0];
            end
            default: ;
        endcase
        w_merged = w_word;
        for (int b = 0; b < 4; b++) begin
            if (w_be[b]) w_merged[8*b +: 8] = w_wdata_sh[8*b +: 8];
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_latch   = 1'b0;
        w_ready   = 1'b1;
        w_rd_out  = '0;
        w_err_out = 1'b0;
        case (r_state)
            StIdle: begin
                if (w_req) begin
                    w_latch   = 1'b1;
                    w_cnt_d   = CNT_INIT;
                    w_state_d = (WAIT_STATES == 0) ? StResp : StWait;
                end
            end
            StWait: begin
                w_ready = 1'b0;
                if (!w_req) begin
                    w_state_d = StIdle;
                    w_cnt_d   = 4'd0;
                end else if (r_cnt == 4'd0) begin
                    w_state_d = StResp;
                end else begin
                    w_cnt_d = r_cnt - 4'd1;
                end
            end
            StResp: begin
                w_err_out = w_err;
                w_rd_out  = (!w_err && r_rd) ? w_load : '0;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign w_commit = (r_state == StResp) && r_wr && !w_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_cnt   <= 4'd0;
            r_addr  <= '0;
            r_size  <= 2'b00;
            r_wdata <= '0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            if (w_latch) begin
                r_addr  <= dmem.i_data_addr[AW-1:0];
                r_size  <= dmem.i_data_rd_en_ctrl;
                r_wdata <= dmem.i_data_wr;
                r_rd    <= dmem.i_data_rd_en_ma;
                r_wr    <= dmem.i_data_wr_en_ma;
            end
        end
    end

    // SRAM contents survive reset.
    always_ff @(posedge clk) begin
        if (w_commit) r_mem[r_addr[AW-1:2]] <= w_merged;
    end

`ifdef DMEM_ACCESS_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_rd_count <= 32'd0;
            o_wr_count <= 32'd0;
        end else if (r_state == StResp && !w_err) begin
            if (r_rd) o_rd_count <= o_rd_count + 32'd1;
            if (r_wr) o_wr_count <= o_wr_count + 32'd1;
        end
    end
`endif

    assign dmem.o_data_ready = w_ready;
    assign dmem.o_data_rd    = w_rd_out;
    assign dmem.o_data_err   = w_err_out;
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Randomized self-checking bench for data_mem_ctrl against a byte-lane memory model.
// Main DUT uses WAIT_STATES=1; two extra instances check latency for 0 and 3.
module tb_data_mem_ctrl;
    localparam int unsigned MAIN_WS = 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_ctrl_if bus ();
    data_mem_ctrl_if bus0 ();
    data_mem_ctrl_if bus3 ();

`ifdef DMEM_ACCESS_COUNT_EN
    logic [31:0] rd_cnt, wr_cnt, rd_cnt0, wr_cnt0, rd_cnt3, wr_cnt3;
`endif

    data_mem_ctrl #(.WAIT_STATES(MAIN_WS)) u_dut (
        .clk(clk), .rst_n(rst_n), .dmem(bus)
`ifdef DMEM_ACCESS_COUNT_EN
        , .o_rd_count(rd_cnt), .o_wr_count(wr_cnt)
`endif
    );
    data_mem_ctrl #(.WAIT_STATES(0)) u_dut_ws0 (
        .clk(clk), .rst_n(rst_n), .dmem(bus0)
`ifdef DMEM_ACCESS_COUNT_EN
        , .o_rd_count(rd_cnt0), .o_wr_count(wr_cnt0)
`endif
    );
    data_mem_ctrl #(.WAIT_STATES(3)) u_dut_ws3 (
        .clk(clk), .rst_n(rst_n), .dmem(bus3)
`ifdef DMEM_ACCESS_COUNT_EN
        , .o_rd_count(rd_cnt3), .o_wr_count(wr_cnt3)
`endif
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    logic [31:0] m_mem [1024];
    int unsigned m_rd_cnt = 0;
    int unsigned m_wr_cnt = 0;
    logic [31:0] last_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // One complete access on the main DUT; expectations come from m_mem.
    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic [1:0] sz, input logic [31:0] addr,
                             input logic [31:0] wd);
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [31:0] word;
        int unsigned idx;
        int unsigned sh;
        @(negedge clk);
        bus.i_data_addr       = addr;
        bus.i_data_wr         = wd;
        bus.i_data_rd_en_ctrl = sz;
        bus.i_data_rd_en_ma   = rd;
        bus.i_data_wr_en_ma   = wr;
        @(posedge clk);
        for (int i = 0; i < MAIN_WS; i++) begin
            @(negedge clk);
            check({tag, "/wait_ready"}, {31'b0, bus.o_data_ready}, 32'd0);
            check({tag, "/wait_rd"}, bus.o_data_rd, 32'd0);
            @(posedge clk);
        end
        @(negedge clk);
        exp_err = (sz == 2'b11) || (rd && wr) || (sz == 2'b01 && addr[0]) ||
                  (sz == 2'b10 && addr[1:0] != 2'b00);
        idx  = int'(addr[11:2]);
        sh   = 8 * int'(addr[1:0]);
        word = m_mem[idx];
        exp_rd = 32'd0;
        if (!exp_err && rd) begin
            case (sz)
                2'b00:   exp_rd = (word >> sh) & 32'h0000_00FF;
                2'b01:   exp_rd = (word >> sh) & 32'h0000_FFFF;
                default: exp_rd = word;
            endcase
            m_rd_cnt++;
        end
        if (!exp_err && wr) begin
            case (sz)
                2'b00:   m_mem[idx][sh +: 8]  = wd[7:0];
                2'b01:   m_mem[idx][sh +: 16] = wd[15:0];
                default: m_mem[idx] = wd;
            endcase
            m_wr_cnt++;
        end
        last_rd = bus.o_data_rd;
        check({tag, "/ready"}, {31'b0, bus.o_data_ready}, 32'd1);
        check({tag, "/rd"}, bus.o_data_rd, exp_rd);
        check({tag, "/err"}, {31'b0, bus.o_data_err}, {31'b0, exp_err});
        bus.i_data_rd_en_ma = 1'b0;
        bus.i_data_wr_en_ma = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "/ready"}, {31'b0, bus.o_data_ready}, 32'd1);
        check({tag, "/rd"}, bus.o_data_rd, 32'd0);
        check({tag, "/err"}, {31'b0, bus.o_data_err}, 32'd0);
    endtask

    initial begin
        int unsigned lat0;
        int unsigned lat3;
        int unsigned low3;
        logic        rd;
        logic        wr;
        logic [1:0]  sz;
        int unsigned pick;

        bus.i_data_addr = '0;  bus.i_data_wr = '0;  bus.i_data_rd_en_ctrl = '0;
        bus.i_data_rd_en_ma = 1'b0;  bus.i_data_wr_en_ma = 1'b0;
        bus0.i_data_addr = '0; bus0.i_data_wr = '0; bus0.i_data_rd_en_ctrl = '0;
        bus0.i_data_rd_en_ma = 1'b0; bus0.i_data_wr_en_ma = 1'b0;
        bus3.i_data_addr = '0; bus3.i_data_wr = '0; bus3.i_data_rd_en_ctrl = '0;
        bus3.i_data_rd_en_ma = 1'b0; bus3.i_data_wr_en_ma = 1'b0;

        // Reset state, during and after reset with no requests.
        repeat (3) begin
            @(negedge clk);
            check_idle("reset_low");
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_idle("reset_idle");
        end

        // Initialise the word window used by all later accesses.
        for (int i = 0; i < 16; i++) do_access("init_sw", 1'b0, 1'b1, 2'b10, i * 4, $urandom);

        do_access("t2_sw", 1'b0, 1'b1, 2'b10, 32'h10, 32'hDEAD_BEEF);
        do_access("t2_lw", 1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
        check("t2_lw_const", last_rd, 32'hDEAD_BEEF);
        do_access("t3_sb", 1'b0, 1'b1, 2'b00, 32'h13, 32'h0000_00AA);
        do_access("t3_lw", 1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
        check("t3_lw_const", last_rd, 32'hAAAD_BEEF);
        do_access("t3_lh", 1'b1, 1'b0, 2'b01, 32'h12, 32'h0);
        check("t3_lh_const", last_rd, 32'h0000_AAAD);
        do_access("t3_lb", 1'b1, 1'b0, 2'b00, 32'h11, 32'h0);
        check("t3_lb_const", last_rd, 32'h0000_00BE);
        do_access("t4_lw_mis", 1'b1, 1'b0, 2'b10, 32'h11, 32'h0);
        do_access("t4_sh_mis", 1'b0, 1'b1, 2'b01, 32'h13, 32'h5555);
        do_access("t4_both", 1'b1, 1'b1, 2'b10, 32'h10, 32'h1111_1111);
        do_access("t4_rsvd", 1'b0, 1'b1, 2'b11, 32'h10, 32'h2222_2222);
        do_access("t4_lw", 1'b1, 1'b0, 2'b10, 32'h10, 32'h0);
        check("t4_lw_const", last_rd, 32'hAAAD_BEEF);

        // Reset pulsed mid-access cancels the store.
        @(negedge clk);
        bus.i_data_addr = 32'h20; bus.i_data_wr = 32'h0000_1234;
        bus.i_data_rd_en_ctrl = 2'b10; bus.i_data_wr_en_ma = 1'b1;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_idle("t5_rst");
        bus.i_data_wr_en_ma = 1'b0;
        m_rd_cnt = 0;
        m_wr_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        do_access("t5_lw", 1'b1, 1'b0, 2'b10, 32'h20, 32'h0);

        // Store aborted by dropping both enables during the wait.
        @(negedge clk);
        bus.i_data_addr = 32'h24; bus.i_data_wr = 32'hCAFE_F00D;
        bus.i_data_rd_en_ctrl = 2'b10; bus.i_data_wr_en_ma = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_data_wr_en_ma = 1'b0;
        @(negedge clk);
        check_idle("abort");
        do_access("abort_lw", 1'b1, 1'b0, 2'b10, 32'h24, 32'h0);

        // Random traffic; upper address bits exercise wrap-around.
        for (int n = 0; n < 300; n++) begin
            pick = $urandom_range(0, 19);
            rd = (pick < 9) || (pick >= 18);
            wr = (pick >= 9);
            sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            do_access("rand", rd, wr, sz, ($urandom & 32'hFFFF_F000) | $urandom_range(0, 63),
                      $urandom);
        end

        // Latency for WAIT_STATES 0 and 3, observed via the error pulse of a misaligned load.
        @(negedge clk);
        bus0.i_data_addr = 32'h41; bus0.i_data_rd_en_ctrl = 2'b10; bus0.i_data_rd_en_ma = 1'b1;
        bus3.i_data_addr = 32'h41; bus3.i_data_rd_en_ctrl = 2'b10; bus3.i_data_rd_en_ma = 1'b1;
        lat0 = 0; lat3 = 0; low3 = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (lat0 == 0 && bus0.o_data_err) begin
                lat0 = c;
                bus0.i_data_rd_en_ma = 1'b0;
            end
            if (lat3 == 0) begin
                if (!bus3.o_data_ready) low3++;
                if (bus3.o_data_err) begin
                    lat3 = c;
                    bus3.i_data_rd_en_ma = 1'b0;
                end
            end
        end
        bus0.i_data_rd_en_ma = 1'b0;
        bus3.i_data_rd_en_ma = 1'b0;
        check("ws0_latency", lat0, 32'd1);
        check("ws3_latency", lat3, 32'd4);
        check("ws3_ready_low", low3, 32'd3);

`ifdef DMEM_ACCESS_COUNT_EN
        @(negedge clk);
        check("rd_count", rd_cnt, m_rd_cnt);
        check("wr_count", wr_cnt, m_wr_cnt);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
